// File: rtl/muldiv_pkg.sv
// Shared types, constants and helpers for the RV32M multiply/divide unit.
// Operation codes follow the funct3 field of the M-extension encoding.
package muldiv_pkg;

  localparam int unsigned MD_XLEN = 32;

  localparam logic [MD_XLEN-1:0] XLEN_MIN_NEG = 32'h8000_0000;
  localparam logic [MD_XLEN-1:0] ALL_ONES     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_OP_DIV)  || (op == MD_OP_DIVU) ||
           (op == MD_OP_REM)  || (op == MD_OP_REMU);
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return (op == MD_OP_REM) || (op == MD_OP_REMU);
  endfunction

  function automatic logic a_signed(input md_op_e op);
    return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_REM);
  endfunction

  function automatic logic b_signed(input md_op_e op);
    return (op == MD_OP_MULH) || (op == MD_OP_DIV) ||
           (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module muldiv_div_step
  import muldiv_pkg::*;
#(
  parameter int unsigned W = MD_XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic         msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Partial remainder stays below 2*divisor, so it fits W+1 bits
  // and a set top bit of the difference means the trial borrowed.
  always_comb begin
    shifted = {rem_i, msb_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[W];
    rem_o   = q_bit_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier path.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ITER_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  md_state_e           state_q, state_d;
  md_op_e              op_q, op_d, op_in;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                spec_q, spec_d;
  logic [XLEN-1:0]     res_q, res_d;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf;

  logic [2*XLEN-1:0]   mul_prod, mul_sgn;
  logic [XLEN-1:0]     mul_res;

  logic [XLEN-1:0]     div_rem;
  logic                div_qbit;
  logic [2*XLEN-1:0]   div_acc;
  logic [XLEN-1:0]     div_quo, div_rmd, div_res;

  assign op_in = md_op_e'(op_i);

  // Operand magnitudes and fast-path detection for the incoming op
  always_comb begin
    a_neg    = a_signed(op_in) & operand_a_i[XLEN-1];
    b_neg    = b_signed(op_in) & operand_b_i[XLEN-1];
    mag_a    = a_neg ? -operand_a_i : operand_a_i;
    mag_b    = b_neg ? -operand_b_i : operand_b_i;
    div_zero = is_div(op_in) && (operand_b_i == '0);
    div_ovf  = ((op_in == MD_OP_DIV) || (op_in == MD_OP_REM)) &&
               (operand_a_i == XLEN_MIN_NEG) &&
               (operand_b_i == ALL_ONES);
  end

`ifdef MULDIV_FAST_MUL_EN
  // Full product of the latched magnitudes in one cycle
  always_comb begin
    mul_prod = (2*XLEN)'(a_q) * (2*XLEN)'(b_q);
  end
`else
  logic [XLEN:0] mul_sum;

  // Shift-add step: acc holds {partial product, remaining multiplier}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               {1'b0, {XLEN{acc_q[0]}} & a_q};
    mul_prod = {mul_sum, acc_q[XLEN-1:1]};
  end
`endif

  // Sign fix-up and half selection of the product
  always_comb begin
    mul_sgn = neg_q ? -mul_prod : mul_prod;
    mul_res = (op_q == MD_OP_MUL) ? mul_sgn[XLEN-1:0]
                                  : mul_sgn[2*XLEN-1:XLEN];
  end

  muldiv_div_step #(
    .W (XLEN)
  ) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .msb_i     (acc_q[XLEN-1]),
    .divisor_i (b_q),
    .rem_o     (div_rem),
    .q_bit_o   (div_qbit)
  );

  // acc holds {remainder, dividend bits shifting into quotient}
  always_comb begin
    div_acc = {div_rem, acc_q[XLEN-2:0], div_qbit};
    div_quo = div_acc[XLEN-1:0];
    div_rmd = div_acc[2*XLEN-1:XLEN];
    div_res = is_rem(op_q) ? (neg_q ? -div_rmd : div_rmd)
                           : (neg_q ? -div_quo : div_quo);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    res_d   = res_q;
    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            op_d   = op_in;
            a_d    = mag_a;
            b_d    = mag_b;
            cnt_d  = ITER_W'(XLEN-1);
            neg_d  = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
            spec_d = div_zero | div_ovf;
            if (is_div(op_in)) begin
              state_d = ST_DIV;
              acc_d   = {{XLEN{1'b0}}, mag_a};
              if (div_zero) begin
                res_d = is_rem(op_in) ? operand_a_i : ALL_ONES;
              end else if (div_ovf) begin
                res_d = is_rem(op_in) ? '0 : XLEN_MIN_NEG;
              end
            end else begin
              state_d = ST_MUL;
              acc_d   = {{XLEN{1'b0}}, mag_b};
            end
          end
        end
        ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          res_d   = mul_res;
          state_d = ST_DONE;
`else
          acc_d = mul_prod;
          if (cnt_q == '0) begin
            res_d   = mul_res;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - ITER_W'(1);
          end
`endif
        end
        ST_DIV: begin
          if (spec_q) begin
            state_d = ST_DONE;
          end else begin
            acc_d = div_acc;
            if (cnt_q == '0) begin
              res_d   = div_res;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q - ITER_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (ready_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= MD_OP_MUL;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      res_q   <= res_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit.
// Multiply latency expectation follows MULDIV_FAST_MUL_EN.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 32;
`endif
  localparam int DL = 32;
  localparam int TMO = 100;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  int n_run  = 0;
  int n_fail = 0;

  ex_muldiv_unit dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .kill_i      (kill_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op for one edge; inputs are scrambled right after accept
  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk_i);
    valid_i     = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    @(posedge clk_i);
    #1;
    valid_i     = 1'b0;
    op_i        = 3'd5;
    operand_a_i = ~a;
    operand_b_i = 32'h1234_5678;
  endtask

  // Edges from accept until valid_o; ready_o must stay low meanwhile
  task automatic wait_valid(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!valid_o && lat < TMO) begin
      if (ready_o) busy_ok = 1'b0;
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        busy_ok;
    logic [31:0] held;
    logic        seen;

    vecs[0]  = '{"divu_100_7",   3'd5, 32'd100,      32'd7,        32'd14,       DL};
    vecs[1]  = '{"remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        DL};
    vecs[2]  = '{"div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DL};
    vecs[3]  = '{"rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DL};
    vecs[4]  = '{"divu_big_2",   3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, DL};
    vecs[5]  = '{"div_by0",      3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[6]  = '{"remu_by0",     3'd7, 32'd5,        32'd0,        32'd5,        1};
    vecs[7]  = '{"div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[8]  = '{"rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[9]  = '{"mulh_min",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, ML};
    vecs[10] = '{"mulhsu_m1",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML};
    vecs[11] = '{"mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
    vecs[12] = '{"mul_max",      3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, ML};
    vecs[13] = '{"mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, ML};
    vecs[14] = '{"div_m7_m2",    3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        DL};
    vecs[15] = '{"divu_0_5",     3'd5, 32'd0,        32'd5,        32'd0,        DL};

    rst_ni      = 1'b0;
    valid_i     = 1'b0;
    op_i        = 3'd0;
    operand_a_i = '0;
    operand_b_i = '0;
    kill_i      = 1'b0;
    ready_i     = 1'b0;
    #3;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat, busy_ok);
      chk({vecs[i].name, "_res"}, result_o, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      if (vecs[i].lat > 1)
        chk({vecs[i].name, "_busy"}, {31'd0, busy_ok}, 32'd1);
      consume();
      chk({vecs[i].name, "_idle"}, {31'd0, ready_o}, 32'd1);
    end

    // Backpressure: result held for 5 cycles while ready_i is low
    start_op(3'd5, 32'd100, 32'd7);
    wait_valid(lat, busy_ok);
    held = result_o;
    chk("bp_first", held, 32'd14);
    seen = 1'b1;
    repeat (5) begin
      @(posedge clk_i);
      #1;
      if (!valid_o || result_o !== 32'd14) seen = 1'b0;
    end
    chk("bp_hold", {31'd0, seen}, 32'd1);
    consume();
    chk("bp_release_rdy", {31'd0, ready_o}, 32'd1);
    chk("bp_release_vld", {31'd0, valid_o}, 32'd0);

    // Kill on the 10th DIV cycle
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    chk("kill_rdy", {31'd0, ready_o}, 32'd1);
    chk("kill_vld", {31'd0, valid_o}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (valid_o) seen = 1'b1;
    end
    chk("kill_no_valid", {31'd0, seen}, 32'd0);

    // Kill in the same cycle as a request: nothing accepted
    @(negedge clk_i);
    kill_i      = 1'b1;
    valid_i     = 1'b1;
    op_i        = 3'd5;
    operand_a_i = 32'd9;
    operand_b_i = 32'd0;
    @(posedge clk_i);
    #1;
    kill_i  = 1'b0;
    valid_i = 1'b0;
    chk("kill_acc_rdy", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    chk("kill_acc_vld", {31'd0, valid_o}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    start_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_vld", {31'd0, valid_o}, 32'd0);
    chk("rst_mid_rdy", {31'd0, ready_o}, 32'd1);
    chk("rst_mid_res", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    start_op(3'd1, 32'hFFFFFFF9, 32'd3);
    wait_valid(lat, busy_ok);
    chk("after_rst_mulh", result_o, 32'hFFFFFFFF);
    chk("after_rst_lat", lat, ML);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
